// File: rtl/fifo_rr_drain_if.sv
// Bundle between the round-robin drain and its source FIFO read ports and downstream consumer.
// master: the drain itself; slave: the FIFOs plus consumer side.
interface fifo_rr_drain_if #(
  parameter int N    = 4,
  parameter int BITS = 32
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]      src_pndng;
  logic [N*BITS-1:0] src_dout;
  logic [N-1:0]      src_pop;
  logic [N-1:0]      src_en;
  logic              out_valid;
  logic              out_ready;
  logic [BITS-1:0]   out_data;
  logic [SW-1:0]     out_src;

  modport master (
    input  src_pndng, src_dout, src_en, out_ready,
    output src_pop, out_valid, out_data, out_src
  );

  modport slave (
    output src_pndng, src_dout, src_en, out_ready,
    input  src_pop, out_valid, out_data, out_src
  );
endinterface

// File: rtl/fifo_rr_drain.sv
// Round-robin drain of N sync FIFO read ports into one registered, source-tagged
// valid/ready stream, with a per-grant burst quantum.
module fifo_rr_drain #(
  parameter int N     = 4,
  parameter int BITS  = 32,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_rr_drain_if.master bus
);
  localparam int SW = $clog2(N);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
  localparam logic [SW-1:0] IDX_LAST = SW'(N - 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   rr_ptr, gnt, pick, gnt_inc;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    req;
  logic            req_any, load_en, pop, burst_end, found;
  logic [BITS-1:0] gnt_data;
  int unsigned     idx;

  assign req      = bus.src_pndng & bus.src_en;
  assign req_any  = |req;
  assign load_en  = !bus.out_valid || bus.out_ready;
  assign gnt_inc  = (gnt == IDX_LAST) ? '0 : gnt + 1'b1;
  assign gnt_data = bus.src_dout[int'(gnt)*BITS +: BITS];

  // A burst ends either on the last quantum pop or as soon as the granted source stops requesting.
  assign pop       = (state == SERVE) && load_en && req[gnt];
  assign burst_end = (state == SERVE) && load_en && (!req[gnt] || (cnt == CNT_LAST));

  // First requesting source at or above rr_ptr, wrapping modulo N.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (rr_ptr + k) % N;
      if (!found && req[idx]) begin
        pick  = SW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any)   state_nxt = SERVE;
      SERVE:   if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.src_pop = '0;
    if (pop) bus.src_pop[gnt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      gnt           <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
    end else begin
      if ((state == IDLE) && req_any) begin
        gnt <= pick;
        cnt <= '0;
      end else if (pop) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end

      if (burst_end) rr_ptr <= gnt_inc;

      if (pop) begin
        bus.out_data  <= gnt_data;
        bus.out_src   <= gnt;
        bus.out_valid <= 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rr_drain.sv
// Directed bench for fifo_rr_drain: per-cycle vector tables plus hand sequences
// for the full round-robin drain and the async reset mid-burst.
module tb_fifo_rr_drain;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_rr_drain_if #(.N(4), .BITS(32)) bus ();

  fifo_rr_drain #(.N(4), .BITS(32), .BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source FIFO models: head data is combinational, pop advances on the clock edge.
  logic [31:0] mem [4][64];
  int wr [4] = '{default: 0};
  int rd [4] = '{default: 0};

  always_comb begin
    bus.src_pndng = '0;
    bus.src_dout  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.src_pndng[i]          = (wr[i] != rd[i]);
      bus.src_dout[i*32 +: 32]  = mem[i][rd[i] % 64];
    end
  end

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (bus.src_pop[i]) rd[i] <= rd[i] + 1;

  task automatic push(input int s, input logic [31:0] d);
    mem[s][wr[s] % 64] = d;
    wr[s]++;
  endtask

  typedef struct {
    logic [1:0]  s;
    logic [31:0] d;
    int          cyc;
  } beat_t;
  beat_t beats[$];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Legality of every pop and capture of every accepted beat.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pop_onehot", 64'($onehot0(bus.src_pop)), 64'd1);
      chk("pop_legal", 64'(bus.src_pop & ~(bus.src_pndng & bus.src_en)), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        beat_t b;
        b.s = bus.out_src;
        b.d = bus.out_data;
        b.cyc = cyc;
        beats.push_back(b);
      end
    end
  end

  typedef struct {
    logic [3:0]  en;
    logic        rdy;
    logic        v;
    logic [3:0]  pop;
    logic [31:0] d;
    logic [1:0]  s;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [3:0] en, input logic rdy, input logic v,
                     input logic [3:0] pop, input logic [31:0] d, input logic [1:0] s);
    vec_t r;
    r.en = en; r.rdy = rdy; r.v = v; r.pop = pop; r.d = d; r.s = s;
    tbl.push_back(r);
  endtask

  // Entered and left just after a rising edge; checks land on the falling edge.
  task automatic run(input int lo, input int hi, input string tag);
    for (int i = lo; i < hi; i++) begin
      bus.src_en    = tbl[i].en;
      bus.out_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("%s[%0d].pop", tag, i - lo), 64'(bus.src_pop), 64'(tbl[i].pop));
      chk($sformatf("%s[%0d].valid", tag, i - lo), 64'(bus.out_valid), 64'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("%s[%0d].data", tag, i - lo), 64'(bus.out_data), 64'(tbl[i].d));
        chk($sformatf("%s[%0d].src", tag, i - lo), 64'(bus.out_src), 64'(tbl[i].s));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int s2, s2b, s4, s5, s6, s_end;

  initial begin
    // single source 2: two-cycle latency, three beats, drain ends the burst
    s2 = tbl.size();
    add(4'hF, 1, 0, 4'b0000, 0, 0);
    add(4'hF, 1, 0, 4'b0100, 0, 0);
    add(4'hF, 1, 1, 4'b0100, 32'hA0, 2);
    add(4'hF, 1, 1, 4'b0100, 32'hA1, 2);
    add(4'hF, 1, 1, 4'b0000, 32'hA2, 2);
    add(4'hF, 1, 0, 4'b0000, 0, 0);
    // sources 0 and 3 both pending: rr_ptr=3 picks source 3 first
    s2b = tbl.size();
    add(4'hF, 1, 0, 4'b0000, 0, 0);
    add(4'hF, 1, 0, 4'b1000, 0, 0);
    add(4'hF, 1, 1, 4'b0000, 32'hC0, 3);
    add(4'hF, 1, 0, 4'b0000, 0, 0);
    add(4'hF, 1, 0, 4'b0001, 0, 0);
    add(4'hF, 1, 1, 4'b0000, 32'hB0, 0);
    add(4'hF, 1, 0, 4'b0000, 0, 0);
    // source 1 streaming under backpressure
    s4 = tbl.size();
    add(4'hF, 1, 0, 4'b0000, 0, 0);
    add(4'hF, 1, 0, 4'b0010, 0, 0);
    add(4'hF, 0, 1, 4'b0000, 32'hD0, 1);
    add(4'hF, 0, 1, 4'b0000, 32'hD0, 1);
    add(4'hF, 1, 1, 4'b0010, 32'hD0, 1);
    add(4'hF, 1, 1, 4'b0010, 32'hD1, 1);
    add(4'hF, 0, 1, 4'b0000, 32'hD2, 1);
    add(4'hF, 0, 1, 4'b0000, 32'hD2, 1);
    add(4'hF, 1, 1, 4'b0010, 32'hD2, 1);
    add(4'hF, 1, 1, 4'b0000, 32'hD3, 1);
    add(4'hF, 1, 0, 4'b0000, 0, 0);
    // src_en[0] dropped after two pops
    s5 = tbl.size();
    add(4'hF, 1, 0, 4'b0000, 0, 0);
    add(4'hF, 1, 0, 4'b0001, 0, 0);
    add(4'hF, 1, 1, 4'b0001, 32'hE0, 0);
    add(4'hE, 1, 1, 4'b0000, 32'hE1, 0);
    add(4'hE, 1, 0, 4'b0000, 0, 0);
    add(4'hE, 1, 0, 4'b0010, 0, 0);
    add(4'hE, 1, 1, 4'b0010, 32'hF0, 1);
    add(4'hE, 1, 1, 4'b0000, 32'hF1, 1);
    add(4'hE, 1, 0, 4'b0000, 0, 0);
    // after reset mid-burst: arbitration restarts at source 0, source 2 resumes at G1
    s6 = tbl.size();
    add(4'hF, 1, 0, 4'b0000, 0, 0);
    add(4'hF, 1, 0, 4'b0001, 0, 0);
    add(4'hF, 1, 1, 4'b0000, 32'h70, 0);
    add(4'hF, 1, 0, 4'b0000, 0, 0);
    add(4'hF, 1, 0, 4'b0100, 0, 0);
    add(4'hF, 1, 1, 4'b0100, 32'h61, 2);
    s_end = tbl.size();

    bus.src_en    = '1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle.valid", 64'(bus.out_valid), 64'd0);
      chk("idle.pop", 64'(bus.src_pop), 64'd0);
      @(posedge clk); #1;
    end
    chk("idle.data", 64'(bus.out_data), 64'd0);
    chk("idle.src", 64'(bus.out_src), 64'd0);

    push(2, 32'hA0); push(2, 32'hA1); push(2, 32'hA2);
    run(s2, s2b, "src2");
    push(0, 32'hB0); push(3, 32'hC0);
    run(s2b, s4, "rrptr");

    // full round-robin drain, 8 entries per source
    do_reset();
    beats.delete();
    for (int s = 0; s < 4; s++)
      for (int j = 0; j < 8; j++) push(s, 32'((s << 8) | j));
    for (int c = 0; c < 200 && beats.size() < 32; c++) @(posedge clk);
    #1;
    chk("rr.count", 64'(beats.size()), 64'd32);
    for (int b = 0; b < beats.size() && b < 32; b++) begin
      int w, s, j;
      w = b % 16;
      s = w / 4;
      j = (b / 16) * 4 + (w % 4);
      chk($sformatf("rr.beat%0d", b), {30'd0, beats[b].s, beats[b].d},
          {30'd0, 2'(s), 32'((s << 8) | j)});
    end
    if (beats.size() >= 32)
      chk("rr.span", 64'(beats[31].cyc - beats[0].cyc + 1), 64'd39);
    repeat (3) @(posedge clk); #1;

    push(1, 32'hD0); push(1, 32'hD1); push(1, 32'hD2); push(1, 32'hD3);
    run(s4, s5, "stall");

    do_reset();
    for (int j = 0; j < 4; j++) push(0, 32'hE0 + j);
    push(1, 32'hF0); push(1, 32'hF1);
    run(s5, s6, "mask");
    chk("mask.src0_popped", 64'(rd[0] - (wr[0] - 4)), 64'd2);
    chk("mask.src0_left", 64'(wr[0] - rd[0]), 64'd2);
    wr[0] = rd[0];
    bus.src_en = '1;

    // reset asserted while a beat is valid and a pop is pending
    do_reset();
    for (int j = 0; j < 4; j++) push(2, 32'h60 + j);
    @(negedge clk);
    @(negedge clk);
    chk("rst.pre_pop", 64'(bus.src_pop), 64'b0100);
    @(negedge clk);
    chk("rst.pre_valid", 64'(bus.out_valid), 64'd1);
    chk("rst.pre_data", 64'(bus.out_data), 64'h60);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.pop", 64'(bus.src_pop), 64'd0);
    chk("rst.data", 64'(bus.out_data), 64'd0);
    @(posedge clk); #1;
    chk("rst.src2_popped", 64'(rd[2] - (wr[2] - 4)), 64'd1);
    rst_n = 1'b1;
    push(0, 32'h70);
    run(s6, s_end, "postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rr_drain.md
Name: fifo_rr_drain

Overview:
- Round-robin scheduler that drains N sync FIFO read ports into one registered output stream with a valid/ready handshake.
- Each FIFO's read side connects directly: pndng in, Dout in, pop out.
- Sits between the per-source ingress FIFOs and a shared downstream consumer.
- Output beats are tagged with the source index; a per-source burst quantum bounds how long one source holds the grant.

Parameters:
N, 4, number of source FIFOs (2..16)
BITS, 32, data width per source
BURST, 4, max consecutive pops per grant (1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous reset, active-low
src_pndng  in  N  per-source FIFO pndng (non-empty)
src_dout  in  N*BITS  per-source FIFO Dout, source i at [i*BITS +: BITS]; combinational head-of-FIFO data
src_pop  out  N  per-source pop, one-hot or zero, combinational
src_en  in  N  per-source enable mask; 0 = never granted
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_data  out  BITS  output beat data
out_src  out  $clog2(N)  source index of out_data (width 1 when N=2)

Behaviour:
- Reset (rst_n low, async): state=IDLE, rr_ptr=0, gnt=0, cnt=0, out_valid=0, out_data=0, out_src=0. src_pop=0 while in reset.
- req = src_pndng & src_en.
- load_en = !out_valid | out_ready (single output register; no skid buffer).
- IDLE state:
  - src_pop=0.
  - If req!=0: gnt <= first set bit of req searching from rr_ptr upward with wrap; cnt <= 0; state <= SERVE.
  - If req==0: remain IDLE.
- SERVE state:
  - Pop condition: load_en & req[gnt]. When true:
    - src_pop[gnt]=1 combinationally.
    - On the edge: out_data <= src_dout[gnt]; out_src <= gnt; out_valid <= 1; cnt <= cnt+1.
  - Burst end by quantum: if a pop occurs with cnt==BURST-1, then rr_ptr <= (gnt+1) mod N and state <= IDLE.
  - Burst end by drain or mask: if load_en & !req[gnt] (source empty or src_en dropped), then no pop, rr_ptr <= (gnt+1) mod N, state <= IDLE.
  - While !load_en: hold state, cnt and gnt; no pop.
- Output register:
  - out_valid & out_ready with no new load -> out_valid <= 0.
  - out_valid & !out_ready -> out_data and out_src held stable.
- Latency and throughput:
  - Source pndng rising while IDLE -> out_valid high 2 cycles later (arbitration cycle, then pop cycle).
  - Sustained throughput is 1 beat/cycle within a burst, with 1 idle arbitration cycle between bursts.
- Pop rules: at most one src_pop bit high per cycle; never pop a source with pndng=0 or src_en=0. Data is captured in the same cycle as the pop (FIFO Dout is valid before the pop advances it).
- Wrap: rr_ptr and gnt arithmetic is mod N; for non-power-of-2 N, index N wraps to 0.
- Fairness: a source continuously requesting is granted within N-1 bursts of other sources.
- cnt width is $clog2(BURST+1) and cnt never exceeds BURST-1.
- Reset mid-burst: the output beat is dropped, and the FIFO already popped in the prior cycle is not replayed.

Test Plan:
- Reset, then src_pndng=0 for 10 cycles -> out_valid=0 and src_pop=0 throughout; out_data=0, out_src=0.
- Source 2 only, 3 entries (0xA0,0xA1,0xA2), out_ready=1 -> out_valid rises 2 cycles after pndng; 3 consecutive beats with out_src=2; then return to IDLE with rr_ptr=3.
- All 4 sources hold 8 entries each, BURST=4, out_ready=1 -> order is src0 x4, src1 x4, src2 x4, src3 x4, src0 x4, ...; one bubble cycle between bursts; 32 beats total, per-source order preserved.
- Source 1 streaming while out_ready toggles 1,0,0,1 -> src_pop low on stall cycles; out_data and out_src stable while stalled; no beat lost or duplicated.
- src_en[0] cleared mid-burst after 2 pops -> burst ends with no further pop of source 0; grant moves to source 1; source 0 remaining entries untouched.
- rst_n asserted low mid-burst with out_valid=1 -> out_valid=0 and src_pop=0 immediately (async); after release, arbitration restarts from rr_ptr=0.
